// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle writeback bypass, a per-register
// busy scoreboard and a four-phase debug access channel that yields to core writeback.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int ADDR_W   = $clog2(REG_NUM),
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            w_regnum_i,
    input  logic [DATA_W-1:0]            w_data_i,
    input  logic [RD_PORTS*ADDR_W-1:0]   r_addr_i,
    output logic [RD_PORTS*DATA_W-1:0]   r_data_o,
    output logic [RD_PORTS-1:0]          r_busy_o,
    input  logic                         sb_set_i,
    input  logic [ADDR_W-1:0]            sb_regnum_i,
    input  logic                         jtag_req_i,
    input  logic                         jtag_we_i,
    input  logic [ADDR_W-1:0]            jtag_regnum_i,
    input  logic [DATA_W-1:0]            jtag_w_data_i,
    output logic                         jtag_ack_o,
    output logic [DATA_W-1:0]            jtag_data_o
);

    // state     | meaning
    // ST_IDLE   | waiting for a debug request; request fields latched on entry to WAIT
    // ST_WAIT   | access pending; deferred while the core is writing back
    // ST_DONE   | access complete, ack held until the requester drops req
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} jtag_state_t;

    jtag_state_t         r_state;
    jtag_state_t         w_state_nxt;
    logic [DATA_W-1:0]   r_regs [REG_NUM];
    logic [REG_NUM-1:0]  r_busy;
    logic                r_jtag_we;
    logic [ADDR_W-1:0]   r_jtag_reg;
    logic [DATA_W-1:0]   r_jtag_wdata;
    logic [DATA_W-1:0]   r_jtag_data;
    logic                w_jtag_access;
    logic                w_jtag_wr;
    logic                w_jtag_rd;

    // An index is "real" if it is in range and not the hardwired zero register.
    function automatic logic f_valid(input logic [ADDR_W-1:0] idx);
        return (int'(idx) < REG_NUM) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] w_idx;
        logic              w_hit;
        assign w_idx = r_addr_i[k*ADDR_W +: ADDR_W];
        assign w_hit = we_i && (w_idx == w_regnum_i);
        assign r_data_o[k*DATA_W +: DATA_W] = !f_valid(w_idx) ? '0 :
                                              w_hit ? w_data_i : r_regs[w_idx];
        assign r_busy_o[k] = f_valid(w_idx) && r_busy[w_idx] && !w_hit;
    end

    // Debug accesses only fire in cycles where the core is not writing, so the
    // two write sources never collide.
    always_comb begin
        w_state_nxt   = r_state;
        w_jtag_access = 1'b0;
        case (r_state)
            ST_IDLE: if (jtag_req_i) w_state_nxt = ST_WAIT;
            ST_WAIT: if (!we_i) begin
                w_jtag_access = 1'b1;
                w_state_nxt   = ST_DONE;
            end
            ST_DONE: if (!jtag_req_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_jtag_wr = w_jtag_access && r_jtag_we && f_valid(r_jtag_reg);
    assign w_jtag_rd = w_jtag_access && !r_jtag_we;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_jtag_we    <= 1'b0;
            r_jtag_reg   <= '0;
            r_jtag_wdata <= '0;
            r_jtag_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && jtag_req_i) begin
                r_jtag_we    <= jtag_we_i;
                r_jtag_reg   <= jtag_regnum_i;
                r_jtag_wdata <= jtag_w_data_i;
            end
            if (w_jtag_rd) begin
                r_jtag_data <= f_valid(r_jtag_reg) ? r_regs[r_jtag_reg] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we_i && f_valid(w_regnum_i)) begin
            r_regs[w_regnum_i] <= w_data_i;
        end else if (w_jtag_wr) begin
            r_regs[r_jtag_reg] <= r_jtag_wdata;
        end
    end

    // Set is applied after clear so a new producer on the same index wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_busy <= '0;
        end else begin
            if (we_i && f_valid(w_regnum_i)) r_busy[w_regnum_i] <= 1'b0;
            if (sb_set_i && f_valid(sb_regnum_i)) r_busy[sb_regnum_i] <= 1'b1;
        end
    end

    assign jtag_ack_o  = (r_state == ST_DONE);
    assign jtag_data_o = r_jtag_data;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: core read/write/scoreboard vectors, debug channel
// sequences, and a second instance with a non-default parametrisation.
module tb_regfile_mp;

    logic        clk;
    logic        rstn;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        sb;
    logic [4:0]  sbreg;
    logic        jreq;
    logic        jwe;
    logic [4:0]  jreg;
    logic [31:0] jwdata;
    logic        jack;
    logic [31:0] jdata;

    logic         p_we;
    logic [3:0]   p_wreg;
    logic [63:0]  p_wdata;
    logic [11:0]  p_raddr;
    logic [191:0] p_rdata;
    logic [2:0]   p_busy;
    logic         p_sb;
    logic [3:0]   p_sbreg;
    logic         p_jack;
    logic [63:0]  p_jdata;

    int n_vec = 0;
    int n_err = 0;

    regfile_mp u_dut (
        .clk(clk), .rstn(rstn), .we_i(we), .w_regnum_i(wreg), .w_data_i(wdata),
        .r_addr_i(raddr), .r_data_o(rdata), .r_busy_o(rbusy),
        .sb_set_i(sb), .sb_regnum_i(sbreg),
        .jtag_req_i(jreq), .jtag_we_i(jwe), .jtag_regnum_i(jreg), .jtag_w_data_i(jwdata),
        .jtag_ack_o(jack), .jtag_data_o(jdata)
    );

    regfile_mp #(.DATA_W(64), .REG_NUM(16), .RD_PORTS(3), .ZERO_REG(0)) u_par (
        .clk(clk), .rstn(rstn), .we_i(p_we), .w_regnum_i(p_wreg), .w_data_i(p_wdata),
        .r_addr_i(p_raddr), .r_data_o(p_rdata), .r_busy_o(p_busy),
        .sb_set_i(p_sb), .sb_regnum_i(p_sbreg),
        .jtag_req_i(1'b0), .jtag_we_i(1'b0), .jtag_regnum_i(4'd0), .jtag_w_data_i(64'd0),
        .jtag_ack_o(p_jack), .jtag_data_o(p_jdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        sb;
        logic [4:0]  sbreg;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        2'b00};
        vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0,        2'b00};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
        vecs[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h0,        32'h0,        2'b11};
        vecs[7]  = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 5'd7, 5'd5, 32'h77,       32'hDEADBEEF, 2'b00};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h77,       32'hDEADBEEF, 2'b00};
        vecs[9]  = '{1'b1, 5'd7, 32'h78,       1'b1, 5'd7, 5'd7, 5'd7, 32'h78,       32'h78,       2'b00};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h78,       32'hDEADBEEF, 2'b01};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd7, 5'd0, 32'h78,       32'h0,        2'b01};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h78,       2'b10};
        vecs[13] = '{1'b1, 5'd7, 32'h99,       1'b1, 5'd9, 5'd9, 5'd7, 32'h0,        32'h99,       2'b00};
        vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd7, 32'h0,        32'h99,       2'b01};
        vecs[15] = '{1'b1, 5'd9, 32'h1,        1'b0, 5'd0, 5'd7, 5'd9, 32'h99,       32'h1,        2'b00};
        vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h1,        32'h1,        2'b00};

        rstn = 1'b0; we = 1'b0; wreg = '0; wdata = '0; raddr = {5'd1, 5'd31};
        sb = 1'b0; sbreg = '0; jreq = 1'b0; jwe = 1'b0; jreg = '0; jwdata = '0;
        p_we = 1'b0; p_wreg = '0; p_wdata = '0; p_raddr = {4'd2, 4'd1, 4'd0};
        p_sb = 1'b0; p_sbreg = '0;

        // reset state
        tick();
        #1;
        chk("rst_rd0", {32'h0, rdata[31:0]}, 64'h0);
        chk("rst_rd1", {32'h0, rdata[63:32]}, 64'h0);
        chk("rst_busy", {62'h0, rbusy}, 64'h0);
        chk("rst_ack", {63'h0, jack}, 64'h0);
        chk("rst_jdata", {32'h0, jdata}, 64'h0);
        chk("rst_p_rd", {32'h0, p_rdata[191:160]} | p_rdata[63:0] | p_rdata[127:64], 64'h0);
        chk("rst_p_busy", {61'h0, p_busy}, 64'h0);
        rstn = 1'b1;
        tick();

        // core read/write/scoreboard vectors
        for (int i = 0; i < 17; i++) begin
            we = vecs[i].we; wreg = vecs[i].wreg; wdata = vecs[i].wdata;
            sb = vecs[i].sb; sbreg = vecs[i].sbreg;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("v%0d_rd0", i), {32'h0, rdata[31:0]}, {32'h0, vecs[i].e0});
            chk($sformatf("v%0d_rd1", i), {32'h0, rdata[63:32]}, {32'h0, vecs[i].e1});
            chk($sformatf("v%0d_busy", i), {62'h0, rbusy}, {62'h0, vecs[i].eb});
            tick();
        end
        sb = 1'b0;

        // debug write deferred by three cycles of core writeback
        jreq = 1'b1; jwe = 1'b1; jreg = 5'd3; jwdata = 32'h12345678;
        we = 1'b1; wreg = 5'd10; wdata = 32'hAAAA0001; raddr = {5'd10, 5'd3};
        #1; chk("jw_ack_c0", {63'h0, jack}, 64'h0);
        tick();
        wdata = 32'hAAAA0002;
        #1; chk("jw_ack_c1", {63'h0, jack}, 64'h0);
        chk("jw_reg3_c1", {32'h0, rdata[31:0]}, 64'h0);
        tick();
        wdata = 32'hAAAA0003;
        #1; chk("jw_reg3_c2", {32'h0, rdata[31:0]}, 64'h0);
        tick();
        we = 1'b0;
        #1; chk("jw_reg3_c3", {32'h0, rdata[31:0]}, 64'h0);
        chk("jw_ack_c3", {63'h0, jack}, 64'h0);
        chk("jw_reg10", {32'h0, rdata[63:32]}, 64'hAAAA0003);
        tick();
        chk("jw_ack_done", {63'h0, jack}, 64'h1);
        chk("jw_reg3_done", {32'h0, rdata[31:0]}, 64'h12345678);
        chk("jw_busy", {62'h0, rbusy}, 64'h0);
        jreq = 1'b0;
        tick();
        chk("jw_ack_drop", {63'h0, jack}, 64'h0);

        // debug read
        we = 1'b1; wreg = 5'd3; wdata = 32'hA5A5A5A5; raddr = {5'd0, 5'd3};
        #1; chk("jr_bypass", {32'h0, rdata[31:0]}, 64'hA5A5A5A5);
        tick();
        we = 1'b0; jreq = 1'b1; jwe = 1'b0; jreg = 5'd3; jwdata = 32'h0;
        tick();
        chk("jr_ack_wait", {63'h0, jack}, 64'h0);
        tick();
        chk("jr_ack_done", {63'h0, jack}, 64'h1);
        chk("jr_data", {32'h0, jdata}, 64'hA5A5A5A5);
        jreq = 1'b0;
        #1; chk("jr_ack_hold", {63'h0, jack}, 64'h1);
        tick();
        chk("jr_ack_drop", {63'h0, jack}, 64'h0);
        chk("jr_data_hold", {32'h0, jdata}, 64'hA5A5A5A5);
        we = 1'b1; wdata = 32'h0;
        tick();
        we = 1'b0;
        #1; chk("jr_data_hold2", {32'h0, jdata}, 64'hA5A5A5A5);

        // reset while a debug write is pending
        jreq = 1'b1; jwe = 1'b1; jreg = 5'd4; jwdata = 32'h55;
        we = 1'b1; wreg = 5'd11; wdata = 32'h1;
        tick();
        rstn = 1'b0; we = 1'b0;
        tick();
        rstn = 1'b1; jreq = 1'b0; raddr = {5'd5, 5'd4};
        #1; chk("rj_ack", {63'h0, jack}, 64'h0);
        chk("rj_jdata", {32'h0, jdata}, 64'h0);
        chk("rj_reg5", {32'h0, rdata[63:32]}, 64'h0);
        tick(); tick();
        chk("rj_reg4", {32'h0, rdata[31:0]}, 64'h0);
        chk("rj_ack2", {63'h0, jack}, 64'h0);

        // 64-bit, 16-entry, 3-port instance without a zero register
        p_we = 1'b1; p_wreg = 4'd0; p_wdata = 64'h0123456789ABCDEF;
        p_sb = 1'b1; p_sbreg = 4'd0; p_raddr = {4'd0, 4'd1, 4'd0};
        #1; chk("p_byp0", p_rdata[63:0], 64'h0123456789ABCDEF);
        chk("p_byp1", p_rdata[127:64], 64'h0);
        chk("p_byp2", p_rdata[191:128], 64'h0123456789ABCDEF);
        chk("p_busy0", {61'h0, p_busy}, 64'h0);
        tick();
        p_we = 1'b0; p_sb = 1'b0;
        #1; chk("p_reg0", p_rdata[63:0], 64'h0123456789ABCDEF);
        chk("p_busy1", {61'h0, p_busy}, 64'h5);
        p_we = 1'b1; p_wreg = 4'd15; p_wdata = 64'hFEDCBA9876543210;
        p_raddr = {4'd15, 4'd0, 4'd15};
        #1; chk("p_b15_0", p_rdata[63:0], 64'hFEDCBA9876543210);
        chk("p_b15_1", p_rdata[127:64], 64'h0123456789ABCDEF);
        chk("p_b15_2", p_rdata[191:128], 64'hFEDCBA9876543210);
        chk("p_busy2", {61'h0, p_busy}, 64'h2);
        tick();
        p_we = 1'b0;
        #1; chk("p_reg15", p_rdata[63:0], 64'hFEDCBA9876543210);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
